// File: rtl/conv_dnn_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_dnn_pkg
//  Description : Shared constants and the beat-record type macro for the
//                conv-to-DNN bridge (C2 outputs -> dnn_top).
//  Revision    : 1.0  initial release
// ============================================================================

// One FIFO entry: per-kernel valid vector, PE data words, set-done flag.
// Kept as a macro so each user can size it from its own parameters.
`ifndef CONV_DNN_BEAT_T
`define CONV_DNN_BEAT_T(NK, NI, BS) struct packed { logic [(NK)-1:0] valid; logic [(NI)-1:0][(BS)-1:0] data; logic set_done; }
`endif

package conv_dnn_pkg;
    localparam int c_bit_size       = 32;  // C2 data word width
    localparam int c_num_in         = 4;   // C2ProcessingElements
    localparam int c_num_of_k       = 8;   // C2NumberOfK
    localparam int c_depth          = 8;
    localparam int c_af_margin      = 2;
    localparam int c_images_per_set = 8;
endpackage

`default_nettype wire

// File: rtl/conv_dnn_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_dnn_bridge_if
//  Description : Beat, handshake and status signals between conv_pooling_top,
//                the bridge and dnn_top. master = environment, slave = bridge.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_dnn_bridge_if
    import conv_dnn_pkg::*;
#(
    parameter int BIT_SIZE       = c_bit_size,
    parameter int NUM_IN         = c_num_in,
    parameter int NUM_OF_K       = c_num_of_k,
    parameter int IMAGES_PER_SET = c_images_per_set
);
    localparam int c_idx_w = $clog2(IMAGES_PER_SET + 1);

    logic [NUM_OF_K-1:0]              in_valid;
    logic [NUM_IN-1:0][BIT_SIZE-1:0]  in_data;
    logic                             in_set_done;
    logic                             in_dnn_ready;
    logic                             out_almost_full;
    logic                             out_overflow;
    logic [NUM_OF_K-1:0]              out_valid;
    logic [NUM_IN-1:0][BIT_SIZE-1:0]  out_data;
    logic                             out_set_done;
    logic                             out_fl_res;
    logic [c_idx_w-1:0]               out_image_idx;

    modport master (
        output in_valid, in_data, in_set_done, in_dnn_ready,
        input  out_almost_full, out_overflow, out_valid, out_data,
               out_set_done, out_fl_res, out_image_idx
    );

    modport slave (
        input  in_valid, in_data, in_set_done, in_dnn_ready,
        output out_almost_full, out_overflow, out_valid, out_data,
               out_set_done, out_fl_res, out_image_idx
    );
endinterface

`default_nettype wire

// File: rtl/conv_dnn_bridge_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_fifo
//  Description : Synchronous single-clock FIFO, power-of-two depth, with
//                occupancy count and full/empty flags. Read data is the
//                current head entry (show-ahead).
//  Revision    : 1.0  initial release
// ============================================================================
module bridge_fifo
    import conv_dnn_pkg::*;
#(
    parameter int WIDTH = c_bit_size,
    parameter int DEPTH = c_depth
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic [WIDTH-1:0]             i_wdata,
    input  wire logic                         i_pop,
    output logic      [WIDTH-1:0]             o_rdata,
    output logic      [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                              o_full,
    output logic                              o_empty
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_rd;
    logic               w_wr;

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Storage array: written at the tail, no reset needed (emptiness is tracked by count).
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/conv_dnn_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : conv_dnn_bridge
//  Description : Buffered link from the C2 stage to dnn_top. Beats pass
//                through a FIFO into an output register that holds until the
//                DNN is ready. Completed images are counted and a one-cycle
//                first-layer reset pulse is issued once per image set.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_dnn_bridge
    import conv_dnn_pkg::*;
#(
    parameter int BIT_SIZE       = c_bit_size,
    parameter int NUM_IN         = c_num_in,
    parameter int NUM_OF_K       = c_num_of_k,
    parameter int DEPTH          = c_depth,
    parameter int AF_MARGIN      = c_af_margin,
    parameter int IMAGES_PER_SET = c_images_per_set,
    parameter int REVERSE_VALID  = 1
) (
    input  wire logic          clk,
    input  wire logic          res,
    conv_dnn_bridge_if.slave   bus
);
    typedef `CONV_DNN_BEAT_T(NUM_OF_K, NUM_IN, BIT_SIZE) bridge_beat_t;

    localparam int c_beat_w = $bits(bridge_beat_t);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_idx_w  = $clog2(IMAGES_PER_SET + 1);
    // almost-full when free entries (DEPTH - count) <= AF_MARGIN
    localparam logic [c_cnt_w-1:0] c_af_level = c_cnt_w'(DEPTH - AF_MARGIN);
    localparam logic [c_idx_w-1:0] c_last_img = c_idx_w'(IMAGES_PER_SET - 1);

    logic [NUM_OF_K-1:0] w_valid_ord;
    bridge_beat_t        w_in_beat;
    bridge_beat_t        w_fifo_rd;
    bridge_beat_t        r_out_beat;
    logic                r_out_occ;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w-1:0]  w_count_next;
    logic                w_full;
    logic                w_empty;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    logic                r_almost_full;
    logic                r_overflow;
    logic [c_idx_w-1:0]  r_image_idx;
    logic                r_fl_res;

    // dnn_top expects the kernel order reversed relative to C2 on the default build.
    generate
        if (REVERSE_VALID != 0) begin : g_rev
            for (genvar i = 0; i < NUM_OF_K; i++) begin : g_bit
                assign w_valid_ord[i] = bus.in_valid[NUM_OF_K-1-i];
            end
        end else begin : g_straight
            assign w_valid_ord = bus.in_valid;
        end
    endgenerate

    assign w_in_beat  = {w_valid_ord, bus.in_data, bus.in_set_done};
    assign w_push_req = (|bus.in_valid) || bus.in_set_done;
    // The output register is occupied exactly when it shows a valid or set-done beat.
    assign w_hs       = r_out_occ && bus.in_dnn_ready;
    assign w_pop      = !w_empty && (!r_out_occ || bus.in_dnn_ready);
    assign w_push     = w_push_req && (!w_full || w_pop);

    bridge_fifo #(
        .WIDTH (c_beat_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (res),
        .i_push  (w_push),
        .i_wdata (w_in_beat),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rd),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy after this edge, so almost-full can be registered without lag.
    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_pop) begin
            w_count_next = w_count + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = w_count - c_cnt_w'(1);
        end
    end

    // Output register: load the head on pop, clear after a handshake with nothing behind it.
    always_ff @(posedge clk) begin
        if (res) begin
            r_out_occ  <= 1'b0;
            r_out_beat <= '0;
        end else if (w_pop) begin
            r_out_occ  <= 1'b1;
            r_out_beat <= w_fifo_rd;
        end else if (w_hs) begin
            r_out_occ  <= 1'b0;
            r_out_beat <= '0;
        end
    end

    // Upstream flow-control flags: almost-full from next count, sticky drop indication.
    always_ff @(posedge clk) begin
        if (res) begin
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_almost_full <= (w_count_next >= c_af_level);
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Image counter advances when a set-done beat is handed to the DNN; pulse on set wrap.
    always_ff @(posedge clk) begin
        if (res) begin
            r_image_idx <= '0;
            r_fl_res    <= 1'b0;
        end else begin
            r_fl_res <= 1'b0;
            if (w_hs && r_out_beat.set_done) begin
                if (r_image_idx == c_last_img) begin
                    r_image_idx <= '0;
                    r_fl_res    <= 1'b1;
                end else begin
                    r_image_idx <= r_image_idx + c_idx_w'(1);
                end
            end
        end
    end

    assign bus.out_almost_full = r_almost_full;
    assign bus.out_overflow    = r_overflow;
    assign bus.out_valid       = r_out_beat.valid;
    assign bus.out_data        = r_out_beat.data;
    assign bus.out_set_done    = r_out_beat.set_done;
    assign bus.out_fl_res      = r_fl_res;
    assign bus.out_image_idx   = r_image_idx;
endmodule

`default_nettype wire

// File: tb/tb_conv_dnn_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_dnn_bridge
//  Description : Self-checking bench for conv_dnn_bridge (Depth 8, AF margin 2,
//                8 images per set, reversed valid order).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_dnn_bridge;
    logic clk = 1'b0;
    logic res = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    conv_dnn_bridge_if #(
        .BIT_SIZE(32), .NUM_IN(4), .NUM_OF_K(8), .IMAGES_PER_SET(8)
    ) bus ();

    conv_dnn_bridge #(
        .BIT_SIZE(32), .NUM_IN(4), .NUM_OF_K(8), .DEPTH(8),
        .AF_MARGIN(2), .IMAGES_PER_SET(8), .REVERSE_VALID(1)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] valid;
        logic       sd;
        logic [7:0] exp_valid;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [127:0] mk(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {32'hD300_0000 + kk, 32'hC200_0000 + kk, 32'hB100_0000 + kk, 32'hA000_0000 + kk};
    endfunction

    task automatic drive(input logic [7:0] v, input logic [127:0] d, input logic sd);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_set_done = sd;
    endtask

    task automatic idle();
        drive(8'h00, 128'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        res = 1'b1;
        repeat (n) step();
        res = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_valid"}, 128'(bus.out_valid), 128'h0);
        chk({nm, "_data"},  bus.out_data, 128'h0);
        chk({nm, "_sd"},    128'(bus.out_set_done), 128'h0);
        chk({nm, "_af"},    128'(bus.out_almost_full), 128'h0);
        chk({nm, "_ovf"},   128'(bus.out_overflow), 128'h0);
        chk({nm, "_fl"},    128'(bus.out_fl_res), 128'h0);
        chk({nm, "_idx"},   128'(bus.out_image_idx), 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] q [$];
        logic [127:0] prev_data;
        logic         prev_present;
        logic         hold;
        logic         present;
        int           cnt;

        tv[0] = '{8'b0000_0011, 1'b0, 8'b1100_0000};
        tv[1] = '{8'b1000_0000, 1'b0, 8'b0000_0001};
        tv[2] = '{8'b1010_0110, 1'b0, 8'b0110_0101};
        tv[3] = '{8'b1111_0000, 1'b0, 8'b0000_1111};
        tv[4] = '{8'b0001_0000, 1'b0, 8'b0000_1000};
        tv[5] = '{8'b0000_0000, 1'b1, 8'b0000_0000};
        tv[6] = '{8'b0000_0000, 1'b0, 8'b0000_0000};

        idle();
        bus.in_dnn_ready = 1'b0;

        // reset state
        res = 1'b1;
        repeat (3) step();
        chk_quiet("rst");
        res = 1'b0;

        // table: single beats, ready high, two-register latency and valid reversal
        bus.in_dnn_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic pres;
            pres = (tv[i].valid != 8'h0) || tv[i].sd;
            drive(tv[i].valid, mk(i + 1), tv[i].sd);
            step();
            idle();
            chk("tv_lat", 128'(bus.out_valid), 128'h0);
            step();
            chk("tv_valid", 128'(bus.out_valid), 128'(tv[i].exp_valid));
            chk("tv_data", bus.out_data, pres ? mk(i + 1) : 128'h0);
            chk("tv_sd", 128'(bus.out_set_done), 128'(tv[i].sd));
            step();
            chk("tv_clear", 128'(bus.out_valid), 128'h0);
        end
        chk("tv_idx", 128'(bus.out_image_idx), 128'd1);

        // fill with DNN stalled: output register holds beat 1, FIFO takes 2..9, 10 is dropped
        do_reset(1);
        bus.in_dnn_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive(8'(k), mk(k), 1'b0);
            step();
            chk("fill_af", 128'(bus.out_almost_full), 128'(k >= 7));
            chk("fill_ovf", 128'(bus.out_overflow), 128'(k >= 10));
            if (k >= 2) chk("fill_hold", bus.out_data, mk(1));
        end
        idle();
        for (int i = 1; i <= 9; i++) begin
            chk("drain_valid", 128'(bus.out_valid), 128'(rev8(8'(i))));
            chk("drain_data", bus.out_data, mk(i));
            bus.in_dnn_ready = 1'b1;
            step();
        end
        chk("drain_empty", 128'(bus.out_valid), 128'h0);
        chk("drain_ovf", 128'(bus.out_overflow), 128'h1);
        chk("drain_af", 128'(bus.out_almost_full), 128'h0);

        // reset mid-stream with beats pending and overflow set
        bus.in_dnn_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(8'hF0, mk(40 + k), 1'b0);
            step();
        end
        res = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            chk_quiet("midrst");
        end
        res = 1'b0;
        idle();
        step();
        chk("midrst_flushed", 128'(bus.out_valid), 128'h0);
        bus.in_dnn_ready = 1'b1;
        drive(8'b0000_0011, mk(77), 1'b0);
        step();
        idle();
        chk("midrst_lat", 128'(bus.out_valid), 128'h0);
        step();
        chk("midrst_valid", 128'(bus.out_valid), 128'hC0);
        chk("midrst_data", bus.out_data, mk(77));

        // push and pop in the same cycle while full
        do_reset(1);
        bus.in_dnn_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            drive(8'(k), mk(k), 1'b0);
            step();
        end
        chk("full_af", 128'(bus.out_almost_full), 128'h1);
        chk("full_ovf", 128'(bus.out_overflow), 128'h0);
        bus.in_dnn_ready = 1'b1;
        drive(8'd10, mk(10), 1'b0);
        step();
        idle();
        chk("pp_ovf", 128'(bus.out_overflow), 128'h0);
        chk("pp_af", 128'(bus.out_almost_full), 128'h1);
        for (int i = 2; i <= 10; i++) begin
            chk("pp_data", bus.out_data, mk(i));
            step();
        end
        chk("pp_empty", 128'(bus.out_valid), 128'h0);
        chk("pp_ovf_end", 128'(bus.out_overflow), 128'h0);

        // 8 images of 4 beats, ready high: beat j shows after edge j+1, leaves at edge j+2
        do_reset(1);
        bus.in_dnn_ready = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e <= 32) drive(8'h01, mk(e), (e % 4) == 0);
            else idle();
            step();
            cnt = 0;
            for (int m = 1; m <= 8; m++) if (4 * m + 2 <= e) cnt++;
            chk("img_idx", 128'(bus.out_image_idx), 128'(cnt % 8));
            chk("img_fl", 128'(bus.out_fl_res), 128'(e == 34));
            if (e >= 2 && e <= 33) begin
                chk("img_data", bus.out_data, mk(e - 1));
                chk("img_sd", 128'(bus.out_set_done), 128'(((e - 1) % 4) == 0));
            end
        end

        // ready toggling with continuous pushes: order, hold while stalled, no loss or duplication
        do_reset(1);
        prev_present = 1'b0;
        prev_data    = '0;
        for (int c = 0; c < 60; c++) begin
            bus.in_dnn_ready = c[0];
            if (c < 12) begin
                drive(8'hFF, mk(500 + c), 1'b0);
                q.push_back(mk(500 + c));
            end else begin
                idle();
            end
            hold = prev_present && !bus.in_dnn_ready;
            step();
            present = (bus.out_valid != 8'h0);
            if (hold) begin
                chk("tog_hold", bus.out_data, prev_data);
            end else if (present) begin
                if (q.size() == 0) begin
                    chk("tog_extra", bus.out_data, 128'h0);
                end else begin
                    chk("tog_data", bus.out_data, q.pop_front());
                end
            end
            prev_present = present;
            prev_data    = bus.out_data;
        end
        chk("tog_remaining", 128'(q.size()), 128'h0);
        chk("tog_ovf", 128'(bus.out_overflow), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
